// File: rtl/op_sequencer_if.sv
// Handshake/bus bundle between the operand sequencer and its environment.
// The slave modport is the sequencer's view; master is the driving side.
interface op_sequencer_if #(
  parameter int unsigned ENTRIES = 16
);
  localparam int unsigned AW = $clog2(ENTRIES);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [21:0]   wr_data;
  logic [AW:0]   count;
  logic          start;
  logic [31:0]   exit;

  logic [5:0]    opc;
  logic [5:0]    func;
  logic [4:0]    Number1;
  logic [4:0]    Number2;
  logic          core_reset;
  logic          res_valid;
  logic [31:0]   res_data;
  logic [AW-1:0] res_index;
  logic          busy;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_data, count, start, exit,
    input  opc, func, Number1, Number2, core_reset,
           res_valid, res_data, res_index, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, count, start, exit,
    output opc, func, Number1, Number2, core_reset,
           res_valid, res_data, res_index, busy, done
  );
endinterface

// File: rtl/op_sequencer.sv
// Steps a CPU core through a table of operand sets: reset the core, let it
// settle, capture its result, then move on to the next entry.
module op_sequencer #(
  parameter int unsigned ENTRIES       = 16,
  parameter int unsigned RST_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic         clock,
  input  logic         reset,
  op_sequencer_if.slave bus
);

  localparam int unsigned AW   = $clog2(ENTRIES);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned MAXC = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PW   = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [PW-1:0] RST_LAST    = PW'(RST_CYCLES - 1);
  localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_MAX   = CW'(ENTRIES);

  typedef struct packed {
    logic [5:0] opc;
    logic [5:0] func;
    logic [4:0] number1;
    logic [4:0] number2;
  } entry_t;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    RUN,
    CAPTURE,
    DONE
  } state_t;

  state_t          state_q, state_nxt;
  logic [PW-1:0]   phase_q, phase_nxt;
  logic [AW-1:0]   idx_q, idx_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  entry_t          op_q, op_nxt;
  logic            core_reset_q, core_reset_nxt;
  logic            busy_q, busy_nxt;
  logic            done_q, done_nxt;
  logic            res_valid_q, res_valid_nxt;
  logic [31:0]     res_data_q, res_data_nxt;
  logic [AW-1:0]   res_index_q, res_index_nxt;

  entry_t          entry_mem [ENTRIES];
  logic [AW-1:0]   idx_inc;
  logic            last_entry;

  // Operand table: deliberately not reset, and frozen while a run is active.
  always_ff @(posedge clock) begin
    if (bus.wr_en && !busy_q) begin
      entry_mem[bus.wr_addr] <= entry_t'(bus.wr_data);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  assign idx_inc    = idx_q + AW'(1);
  assign last_entry = ({1'b0, idx_q} == (cnt_q - CW'(1)));

  always_comb begin
    state_nxt     = state_q;
    phase_nxt     = phase_q;
    idx_nxt       = idx_q;
    cnt_nxt       = cnt_q;
    op_nxt        = op_q;
    res_valid_nxt = 1'b0;
    res_data_nxt  = res_data_q;
    res_index_nxt = res_index_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.count == '0) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt   = (bus.count > COUNT_MAX) ? COUNT_MAX : bus.count;
            idx_nxt   = '0;
            op_nxt    = entry_mem[0];
            phase_nxt = '0;
            state_nxt = RST;
          end
        end
      end

      RST: begin
        if (phase_q == RST_LAST) begin
          phase_nxt = '0;
          state_nxt = RUN;
        end else begin
          phase_nxt = phase_q + PW'(1);
        end
      end

      RUN: begin
        if (phase_q == SETTLE_LAST) begin
          phase_nxt = '0;
          state_nxt = CAPTURE;
        end else begin
          phase_nxt = phase_q + PW'(1);
        end
      end

      // Result is taken from the core on the edge that leaves CAPTURE.
      CAPTURE: begin
        res_valid_nxt = 1'b1;
        res_data_nxt  = bus.exit;
        res_index_nxt = idx_q;
        if (last_entry) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx_inc;
          op_nxt    = entry_mem[idx_inc];
          phase_nxt = '0;
          state_nxt = RST;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Status outputs are registered copies of the state being entered.
    busy_nxt       = (state_nxt != IDLE);
    done_nxt       = (state_nxt == DONE);
    core_reset_nxt = !((state_nxt == RUN) || (state_nxt == CAPTURE));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q      <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      op_q         <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_index_q  <= '0;
    end else begin
      phase_q      <= phase_nxt;
      idx_q        <= idx_nxt;
      cnt_q        <= cnt_nxt;
      op_q         <= op_nxt;
      core_reset_q <= core_reset_nxt;
      busy_q       <= busy_nxt;
      done_q       <= done_nxt;
      res_valid_q  <= res_valid_nxt;
      res_data_q   <= res_data_nxt;
      res_index_q  <= res_index_nxt;
    end
  end

  assign bus.opc        = op_q.opc;
  assign bus.func       = op_q.func;
  assign bus.Number1    = op_q.number1;
  assign bus.Number2    = op_q.number2;
  assign bus.core_reset = core_reset_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_index  = res_index_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: per-cycle traces of each run are checked
// against hand-derived timing (11-cycle entry period) and a shadow table.
module tb_op_sequencer;

  localparam int unsigned ENTRIES = 16;
  localparam int          PERIOD  = 11;
  localparam logic [31:0] SALT    = 32'h5A5A_0000;

  logic clock;
  logic reset;

  op_sequencer_if #(.ENTRIES(ENTRIES)) bus ();

  op_sequencer #(
    .ENTRIES(ENTRIES),
    .RST_CYCLES(2),
    .SETTLE_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  // Core stand-in: garbage while held in reset, operand-derived value otherwise.
  assign bus.exit = bus.core_reset ? 32'hDEAD_BEEF
                  : ({10'h0, bus.opc, bus.func, bus.Number1, bus.Number2} ^ SALT);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks;
  int n_fail;

  logic [21:0] shadow [ENTRIES];

  logic        tr_cr    [256];
  logic        tr_busy  [256];
  logic        tr_rv    [256];
  logic        tr_done  [256];
  logic [3:0]  tr_idx   [256];
  logic [31:0] tr_data  [256];
  logic [21:0] tr_ops   [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_entry(input logic [3:0] addr, input logic [21:0] data);
    @(negedge clock);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(negedge clock);
    bus.wr_en   = 1'b0;
    shadow[addr] = data;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_core_reset"}, 32'(bus.core_reset), 32'd1);
    check({tag, "_busy"},       32'(bus.busy),       32'd0);
    check({tag, "_done"},       32'(bus.done),       32'd0);
    check({tag, "_res_valid"},  32'(bus.res_valid),  32'd0);
    check({tag, "_res_data"},   bus.res_data,        32'd0);
    check({tag, "_res_index"},  32'(bus.res_index),  32'd0);
    check({tag, "_operands"},   32'({bus.opc, bus.func, bus.Number1, bus.Number2}), 32'd0);
  endtask

  // Pulse start and record ncyc cycles; optionally poke start+write while busy,
  // or assert reset at a given cycle (returns right after the async check).
  task automatic run_trace(input int cnt, input int ncyc, input int poke_at, input int rst_at);
    for (int i = 0; i < 256; i++) begin
      tr_cr[i] = 1'b0; tr_busy[i] = 1'b0; tr_rv[i] = 1'b0; tr_done[i] = 1'b0;
      tr_idx[i] = '0;  tr_data[i] = '0;   tr_ops[i] = '0;
    end
    @(negedge clock);
    bus.count = 5'(cnt);
    bus.start = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clock);
      tr_cr[i]   = bus.core_reset;
      tr_busy[i] = bus.busy;
      tr_rv[i]   = bus.res_valid;
      tr_done[i] = bus.done;
      tr_idx[i]  = bus.res_index;
      tr_data[i] = bus.res_data;
      tr_ops[i]  = {bus.opc, bus.func, bus.Number1, bus.Number2};
      if (i == 1) bus.start = 1'b0;
      if (i == poke_at) begin
        bus.start   = 1'b1;
        bus.count   = 5'd1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd1;
        bus.wr_data = 22'h3F_FFFF;
      end
      if (i == poke_at + 1) begin
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
      end
      if (i == rst_at) begin
        reset = 1'b1;
        #1;
        check_reset_values("midrun");
        break;
      end
    end
  endtask

  // Entry k: RST at 1+11k, RUN from 3+11k, CAPTURE at 11+11k, res_valid at 12+11k.
  task automatic check_run(input string tag, input int n, input int ncyc);
    int rv_n;
    int done_n;
    int b;
    rv_n = 0;
    done_n = 0;
    for (int i = 1; i <= ncyc; i++) begin
      rv_n   += int'(tr_rv[i]);
      done_n += int'(tr_done[i]);
    end
    check({tag, "_rv_count"},   32'(rv_n),   32'(n));
    check({tag, "_done_count"}, 32'(done_n), 32'd1);
    for (int k = 0; k < n; k++) begin
      b = 1 + PERIOD * k;
      check({tag, "_cr_rst0"},  32'(tr_cr[b]),      32'd1);
      check({tag, "_cr_rst1"},  32'(tr_cr[b + 1]),  32'd1);
      check({tag, "_cr_run"},   32'(tr_cr[b + 2]),  32'd0);
      check({tag, "_cr_cap"},   32'(tr_cr[b + 10]), 32'd0);
      check({tag, "_ops_run"},  32'(tr_ops[b + 5]), 32'(shadow[k]));
      check({tag, "_rv"},       32'(tr_rv[b + 11]), 32'd1);
      check({tag, "_rv_index"}, 32'(tr_idx[b + 11]), 32'(k));
      check({tag, "_rv_data"},  tr_data[b + 11], {10'h0, shadow[k]} ^ SALT);
    end
    check({tag, "_done_at"}, 32'(tr_done[1 + PERIOD * n]), 32'd1);
    check({tag, "_busy_end"}, 32'(tr_busy[2 + PERIOD * n]), 32'd0);
    check({tag, "_cr_idle"},  32'(tr_cr[2 + PERIOD * n]),   32'd1);
  endtask

  int rv_n;
  int done_n;
  int busy_n;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.count   = '0;
    bus.start   = 1'b0;
    for (int i = 0; i < int'(ENTRIES); i++) shadow[i] = '0;

    repeat (2) @(negedge clock);
    check_reset_values("por");
    reset = 1'b0;

    // Single entry run
    write_entry(4'd0, {6'd0, 6'h20, 5'd1, 5'd2});
    run_trace(1, 3 + PERIOD, 0, 0);
    check_run("one", 1, 3 + PERIOD);
    check("one_busy_first", 32'(tr_busy[1]), 32'd1);

    // Three entries back to back
    write_entry(4'd1, {6'h0A, 6'h15, 5'd7, 5'd19});
    write_entry(4'd2, {6'h3F, 6'h01, 5'd31, 5'd0});
    run_trace(3, 3 + 3 * PERIOD, 0, 0);
    check_run("three", 3, 3 + 3 * PERIOD);

    // start/count/write while busy must be ignored
    run_trace(3, 3 + 3 * PERIOD, 15, 0);
    check_run("poke", 3, 3 + 3 * PERIOD);
    run_trace(2, 3 + 2 * PERIOD, 0, 0);
    check_run("retain", 2, 3 + 2 * PERIOD);

    // count=0: immediate done, no result, core held in reset, outputs held
    run_trace(0, 4, 0, 0);
    check("zero_done",     32'(tr_done[1]), 32'd1);
    check("zero_done_end", 32'(tr_done[2]), 32'd0);
    check("zero_busy_end", 32'(tr_busy[2]), 32'd0);
    check("zero_rv",       32'(tr_rv[1] | tr_rv[2] | tr_rv[3]), 32'd0);
    check("zero_cr",       32'(tr_cr[1] & tr_cr[2] & tr_cr[3]), 32'd1);
    check("zero_ops",      32'(tr_ops[2]), 32'(shadow[1]));
    check("zero_idx_hold", 32'(tr_idx[2]), 32'd1);
    check("zero_data_hold", tr_data[2], {10'h0, shadow[1]} ^ SALT);

    // Reset during RUN of entry 1 of 4, then restart from entry 0
    write_entry(4'd3, {6'h12, 6'h2A, 5'd4, 5'd9});
    run_trace(4, 3 + 4 * PERIOD, 0, 16);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    rv_n = 0;
    done_n = 0;
    busy_n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      rv_n   += int'(bus.res_valid);
      done_n += int'(bus.done);
      busy_n += int'(bus.busy);
    end
    check("abort_no_rv",   32'(rv_n),   32'd0);
    check("abort_no_done", 32'(done_n), 32'd0);
    check("abort_no_busy", 32'(busy_n), 32'd0);
    run_trace(2, 3 + 2 * PERIOD, 0, 0);
    check_run("restart", 2, 3 + 2 * PERIOD);

    // count above table depth is clamped
    for (int i = 0; i < int'(ENTRIES); i++) begin
      write_entry(4'(i), {6'(i + 1), 6'(i * 3), 5'(i), 5'(31 - i)});
    end
    run_trace(int'(ENTRIES) + 1, 3 + int'(ENTRIES) * PERIOD, 0, 0);
    check_run("clamp", int'(ENTRIES), 3 + int'(ENTRIES) * PERIOD);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/op_sequencer.md
OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 Parameter ENTRIES, default 16, table depth (power of two, >=2); AW = log2(ENTRIES).
REQ-002 Parameter RST_CYCLES, default 2, cycles core_reset is held high per entry (>=1).
REQ-003 Parameter SETTLE_CYCLES, default 8, cycles the core runs before its result is sampled (>=1).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clock  in  1  rising-edge system clock.
REQ-006 reset  in  1  asynchronous, active-high block reset.
REQ-007 wr_en  in  1  write one table entry this cycle.
REQ-008 wr_addr  in  AW  table entry index.
REQ-009 wr_data  in  22  entry {opc[21:16], func[15:10], Number1[9:5], Number2[4:0]}.
REQ-010 count  in  AW+1  number of entries to run, 0..ENTRIES, sampled at start.
REQ-011 start  in  1  begin a run (single-cycle pulse or level).
REQ-012 exit  in  32  result from the CPU core.
REQ-013 opc  out  6, func  out  6, Number1  out  5, Number2  out  5: operands driven to the core.
REQ-014 core_reset  out  1  reset to the CPU core, active-high.
REQ-015 res_valid  out  1  one-cycle pulse, res_data/res_index valid.
REQ-016 res_data  out  32  captured exit value; res_index  out  AW  entry that produced it.
REQ-017 busy  out  1  run in progress; done  out  1  one-cycle end-of-run pulse.

Function
REQ-018 All outputs SHALL be registered; states: IDLE, RST, RUN, CAPTURE, DONE.
REQ-019 Table write: wr_en=1 and busy=0 SHALL write wr_data to table[wr_addr] at the clock edge; wr_en while busy=1 SHALL be ignored; table contents are not cleared by reset.
REQ-020 IDLE: start=1 and count>0 SHALL latch count, set idx=0, load operands from table[0], enter RST next cycle, busy=1.
REQ-021 IDLE: start=1 and count=0 SHALL go to DONE (done pulse, no res_valid, operands unchanged).
REQ-022 start while busy=1 SHALL be ignored; count changes while busy SHALL have no effect.
REQ-023 RST: core_reset=1 for exactly RST_CYCLES cycles with operands = table[idx], then RUN.
REQ-024 RUN: core_reset=0 for exactly SETTLE_CYCLES cycles, operands stable, then CAPTURE.
REQ-025 CAPTURE: one cycle, core_reset=0; at its closing edge exit SHALL be registered into res_data, res_index=idx, res_valid=1 for the following cycle only.
REQ-026 CAPTURE with idx = latched count-1 SHALL go to DONE; otherwise idx+1, operands reload from table[idx+1], go to RST.
REQ-027 Per-entry period SHALL be RST_CYCLES+SETTLE_CYCLES+1 cycles; entry spacing of res_valid pulses equals this period.
REQ-028 DONE: one cycle, done=1, busy=0 in the following cycle, return to IDLE; start sampled in DONE SHALL be ignored.
REQ-029 core_reset SHALL be 1 in IDLE, RST and DONE, 0 only in RUN and CAPTURE.
REQ-030 count > ENTRIES SHALL be clamped to ENTRIES when latched.
REQ-031 res_data/res_index SHALL hold their last values between res_valid pulses.

Reset
REQ-032 reset=1 SHALL immediately (asynchronously) force: state IDLE, core_reset=1, busy=0, done=0, res_valid=0, res_data=0, res_index=0, opc=func=Number1=Number2=0, idx=0.
REQ-033 reset mid-run SHALL abandon the run with no done pulse and no further res_valid; the next start after release SHALL begin from entry 0.

Verification
REQ-034 Write entry0={opc=0,func=0x20,N1=1,N2=2}, count=1, start -> core_reset high 2 cycles, low 9 cycles, res_valid once with res_index=0, res_data=exit sampled, done pulse, busy low.
REQ-035 Write 3 entries, count=3, start -> three res_valid pulses 11 cycles apart, res_index 0,1,2, operands match each entry during its RUN, single done after the third.
REQ-036 count=0, start -> done pulse next cycle after DONE entry, no res_valid, core_reset stays 1.
REQ-037 Mid-run: start again and wr_en to entry1 with new data while busy -> both ignored; run outputs unchanged and table entry1 retains old value.
REQ-038 Assert reset during RUN of entry 1 of 4 -> outputs at reset values within same cycle, no done; restart -> res_index sequence restarts at 0.
REQ-039 count=ENTRIES+1 (e.g. 17 with default) -> exactly 16 res_valid pulses, index 0..15 then done.
